// File: rtl/reset_scheduler.sv
// reset_scheduler: arms on a programmed time of day and walks clr_idx over every seat with a req/ack handshake.
// Define SCHED_REPEAT_EN to re-arm daily with the same trigger; undefined gives one-shot behaviour.
`default_nettype none

module reset_scheduler #(
    parameter int NUM_SEATS = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] i_time_in,
    input  logic        i_cfg_valid,
    input  logic [10:0] i_cfg_time,
    output logic        o_cfg_ready,
    output logic        o_cfg_err,
    output logic        o_clr_req,
    output logic [5:0]  o_clr_idx,
    input  logic        i_clr_ack,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMED    = 3'd1,
        S_CLEAR    = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [5:0] c_LAST_IDX = 6'(NUM_SEATS - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [10:0] r_time_q;
    logic [10:0] r_trig;
    logic [5:0]  r_idx;
    logic [5:0]  w_idx_nxt;
    logic        r_cfg_err;

    logic        w_ready;
    logic        w_xfer;
    logic        w_cfg_ok;
    logic        w_load;
    logic        w_tick;
    logic        w_hit;

    assign w_ready  = (r_state == S_IDLE) || (r_state == S_ARMED) || (r_state == S_DONE);
    assign w_xfer   = i_cfg_valid && w_ready;
    assign w_cfg_ok = (i_cfg_time[10:6] < 5'd24) && (i_cfg_time[5:0] < 6'd60);
    assign w_load   = w_xfer && w_cfg_ok;
    assign w_tick   = (i_time_in != r_time_q);
    assign w_hit    = w_tick && (i_time_in == r_trig);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_load) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                // A configuration transfer takes priority over a coincident tick.
                if (!w_xfer && w_hit) begin
                    w_state_nxt = S_CLEAR;
                    w_idx_nxt   = 6'd0;
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (i_clr_ack) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt = S_DONE;
                        w_idx_nxt   = 6'd0;
                    end else begin
                        w_idx_nxt = r_idx + 6'd1;
                    end
                end
            end
            S_DONE: begin
                if (w_load) begin
                    w_state_nxt = S_ARMED;
                end else begin
`ifdef SCHED_REPEAT_EN
                    w_state_nxt = S_ARMED;
`else
                    w_state_nxt = S_IDLE;
`endif
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_time_q  <= 11'd0;
            r_trig    <= 11'd0;
            r_idx     <= 6'd0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_time_q  <= i_time_in;
            r_idx     <= w_idx_nxt;
            r_cfg_err <= w_xfer && !w_cfg_ok;
            if (w_load) r_trig <= i_cfg_time;
        end
    end

    assign o_cfg_ready = w_ready;
    assign o_cfg_err   = r_cfg_err;
    assign o_clr_req   = (r_state == S_CLEAR) || (r_state == S_WAIT_ACK);
    assign o_busy      = (r_state == S_CLEAR) || (r_state == S_WAIT_ACK);
    assign o_clr_idx   = r_idx;
    assign o_done      = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_reset_scheduler.sv
// tb_reset_scheduler: directed scenario tasks for reset_scheduler with NUM_SEATS = 40.
`default_nettype none

module tb_reset_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] i_time_in = 11'd0;
    logic        i_cfg_valid = 1'b0;
    logic [10:0] i_cfg_time = 11'd0;
    logic        o_cfg_ready;
    logic        o_cfg_err;
    logic        o_clr_req;
    logic [5:0]  o_clr_idx;
    logic        i_clr_ack = 1'b0;
    logic        o_busy;
    logic        o_done;

    int errors = 0;
    int checks = 0;

    reset_scheduler #(.NUM_SEATS(40)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_time_in  (i_time_in),
        .i_cfg_valid(i_cfg_valid),
        .i_cfg_time (i_cfg_time),
        .o_cfg_ready(o_cfg_ready),
        .o_cfg_err  (o_cfg_err),
        .o_clr_req  (o_clr_req),
        .o_clr_idx  (o_clr_idx),
        .i_clr_ack  (i_clr_ack),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] tm(input int h, input int m);
        return {5'(h), 6'(m)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_clr_ack   = 1'b0;
        i_cfg_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic program_time(input logic [10:0] t);
        i_cfg_valid = 1'b1;
        i_cfg_time  = t;
        step();
        i_cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if ({o_cfg_ready, o_cfg_err, o_clr_req, o_busy, o_done} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags: got ready/err/req/busy/done=%b expected 10000",
                     {o_cfg_ready, o_cfg_err, o_clr_req, o_busy, o_done});
        end
        checks++;
        if (o_clr_idx !== 6'd0) begin
            errors++;
            $display("FAIL reset_idx: got %0d expected 0", o_clr_idx);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        i_time_in = tm(8, 29);
        step();
        program_time(tm(8, 30));
        checks++;
        if (o_cfg_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL armed_state: got ready=%b busy=%b expected 1 0", o_cfg_ready, o_busy);
        end
        i_time_in = tm(8, 30);
        step();
        checks++;
        if (o_clr_req !== 1'b1 || o_clr_idx !== 6'd0 || o_cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL trigger: got req=%b idx=%0d ready=%b expected 1 0 0",
                     o_clr_req, o_clr_idx, o_cfg_ready);
        end
        i_clr_ack = 1'b1;
        step();
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (o_clr_req !== 1'b1 || o_clr_idx !== 6'(i) || o_done !== 1'b0) begin
                errors++;
                $display("FAIL seq_idx: got req=%b idx=%0d done=%b expected 1 %0d 0",
                         o_clr_req, o_clr_idx, o_done, i);
            end
            step();
        end
        checks++;
        if (o_done !== 1'b1 || o_clr_req !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got done=%b req=%b busy=%b expected 1 0 0",
                     o_done, o_clr_req, o_busy);
        end
        i_clr_ack = 1'b0;
        step();
        checks++;
        if (o_done !== 1'b0 || o_cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL done_end: got done=%b ready=%b expected 0 1", o_done, o_cfg_ready);
        end
        i_time_in = tm(8, 31);
        step();
        i_time_in = tm(8, 30);
        step();
        checks++;
`ifdef SCHED_REPEAT_EN
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL rearm: got busy=%b expected 1", o_busy);
        end
`else
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL one_shot: got busy=%b expected 0", o_busy);
        end
`endif
    endtask

    task automatic test_cfg_err();
        int seen;
        do_reset();
        i_time_in = tm(0, 0);
        step();
        program_time(tm(24, 0));
        checks++;
        if (o_cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL cfg_err_hour: got %b expected 1", o_cfg_err);
        end
        step();
        checks++;
        if (o_cfg_err !== 1'b0 || o_cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_err_pulse: got err=%b ready=%b expected 0 1", o_cfg_err, o_cfg_ready);
        end
        program_time(tm(5, 60));
        checks++;
        if (o_cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL cfg_err_min: got %b expected 1", o_cfg_err);
        end
        seen = 0;
        i_time_in = tm(0, 1);
        step();
        i_time_in = tm(0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            if (o_clr_req !== 1'b0 || o_busy !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL cfg_err_no_arm: got %0d busy cycles expected 0", seen);
        end
    endtask

    task automatic test_priority();
        do_reset();
        i_time_in = tm(6, 59);
        step();
        program_time(tm(7, 0));
        i_time_in   = tm(7, 0);
        i_cfg_valid = 1'b1;
        i_cfg_time  = tm(7, 5);
        step();
        i_cfg_valid = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_wins: got busy=%b ready=%b expected 0 1", o_busy, o_cfg_ready);
        end
        i_time_in = tm(7, 5);
        step();
        checks++;
        if (o_busy !== 1'b1 || o_clr_req !== 1'b1) begin
            errors++;
            $display("FAIL new_trigger: got busy=%b req=%b expected 1 1", o_busy, o_clr_req);
        end
    endtask

    task automatic test_steady();
        int starts;
        int dones;
        logic prev;
        do_reset();
        i_time_in = tm(11, 59);
        step();
        program_time(tm(12, 0));
        i_time_in = tm(12, 0);
        i_clr_ack = 1'b1;
        starts = 0;
        dones = 0;
        prev = 1'b0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (o_clr_req && !prev) starts++;
            prev = o_clr_req;
            if (o_done) dones++;
        end
        i_clr_ack = 1'b0;
        checks++;
        if (starts !== 1 || dones !== 1) begin
            errors++;
            $display("FAIL steady_once: got starts=%0d dones=%0d expected 1 1", starts, dones);
        end
    endtask

    task automatic test_stall_and_abort();
        int bad;
        int n;
        do_reset();
        i_time_in = tm(9, 59);
        step();
        program_time(tm(10, 0));
        i_time_in = tm(10, 0);
        step();
        i_clr_ack = 1'b1;
        step();
        checks++;
        if (o_clr_req !== 1'b1 || o_clr_idx !== 6'd0) begin
            errors++;
            $display("FAIL ack_in_clear: got req=%b idx=%0d expected 1 0", o_clr_req, o_clr_idx);
        end
        n = 0;
        while (o_clr_idx !== 6'd5 && n < 10) begin
            step();
            n++;
        end
        i_clr_ack = 1'b0;
        checks++;
        if (o_clr_idx !== 6'd5) begin
            errors++;
            $display("FAIL reach_idx5: got idx=%0d expected 5 (timeout)", o_clr_idx);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_clr_req !== 1'b1 || o_clr_idx !== 6'd5) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad);
        end
        i_clr_ack = 1'b1;
        step();
        checks++;
        if (o_clr_idx !== 6'd6 || o_clr_req !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got idx=%0d req=%b expected 6 1", o_clr_idx, o_clr_req);
        end
        n = 0;
        while (o_clr_idx !== 6'd17 && n < 20) begin
            step();
            n++;
        end
        i_clr_ack = 1'b0;
        checks++;
        if (o_clr_idx !== 6'd17) begin
            errors++;
            $display("FAIL reach_idx17: got idx=%0d expected 17 (timeout)", o_clr_idx);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({o_cfg_ready, o_cfg_err, o_clr_req, o_busy, o_done} !== 5'b10000 || o_clr_idx !== 6'd0) begin
            errors++;
            $display("FAIL abort: got ready/err/req/busy/done=%b idx=%0d expected 10000 0",
                     {o_cfg_ready, o_cfg_err, o_clr_req, o_busy, o_done}, o_clr_idx);
        end
        rst = 1'b0;
        i_clr_ack = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            i_time_in = (i % 2 == 0) ? tm(10, 1) : tm(10, 0);
            step();
            if (o_clr_req || o_done) bad++;
        end
        i_clr_ack = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL post_abort_quiet: got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_repeat();
        int h;
        int m;
        int dones;
        int starts;
        int exp_n;
        logic prev;
        do_reset();
        h = 23;
        m = 58;
        i_time_in = tm(h, m);
        step();
        program_time(tm(23, 59));
        i_clr_ack = 1'b1;
        dones = 0;
        starts = 0;
        prev = 1'b0;
        for (int i = 0; i < 1450; i++) begin
            m++;
            if (m == 60) begin
                m = 0;
                h++;
                if (h == 24) h = 0;
            end
            i_time_in = tm(h, m);
            step();
            if (o_clr_req && !prev) starts++;
            prev = o_clr_req;
            if (o_done) dones++;
        end
        i_clr_ack = 1'b0;
`ifdef SCHED_REPEAT_EN
        exp_n = 2;
`else
        exp_n = 1;
`endif
        checks++;
        if (dones !== exp_n || starts !== exp_n) begin
            errors++;
            $display("FAIL daily_repeat: got dones=%0d starts=%0d expected %0d", dones, starts, exp_n);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cfg_err();
        test_priority();
        test_steady();
        test_stall_and_abort();
        test_repeat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reset_scheduler.md
RESET_SCHEDULER -- requirements
Module: reset_scheduler

Interface
REQ-001 Parameter NUM_SEATS, default 40, range 1..64: number of seat slots cleared per trigger.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 time_in  input  11  current time packed {hour[10:6] (0..23), min[5:0] (0..59)} from the timekeeping block.
REQ-005 cfg_valid  input  1  request to program a trigger time.
REQ-006 cfg_time  input  11  trigger time, same packing as time_in.
REQ-007 cfg_ready  output  1  high when a cfg_valid is accepted this cycle.
REQ-008 cfg_err  output  1  one-cycle pulse: accepted cfg_time was out of range.
REQ-009 clr_req  output  1  seat-clear request to the seat table.
REQ-010 clr_idx  output  6  seat index for the current clr_req.
REQ-011 clr_ack  input  1  seat table has consumed the current clr_idx.
REQ-012 busy  output  1  high in CLEAR and WAIT_ACK.
REQ-013 done  output  1  one-cycle pulse after the last seat is acknowledged.

Function
REQ-014 States SHALL be IDLE, ARMED, CLEAR, WAIT_ACK, DONE.
REQ-015 cfg_ready SHALL be high in IDLE, ARMED and DONE, low in CLEAR and WAIT_ACK; a transfer occurs when cfg_valid && cfg_ready.
REQ-016 On transfer, cfg_time with hour<24 and min<60 SHALL load the trigger register and move to ARMED next cycle.
REQ-017 On transfer with hour>23 or min>59, the trigger register and state SHALL be unchanged and cfg_err SHALL pulse the next cycle.
REQ-018 A registered copy of time_in SHALL be kept; a "tick" is any cycle where time_in differs from that copy.
REQ-019 In ARMED, a tick with time_in equal to the trigger register SHALL move to CLEAR next cycle; a steady matching time_in without a tick SHALL NOT trigger.
REQ-020 A tick and a valid cfg transfer in the same ARMED cycle: the cfg transfer SHALL win and the tick SHALL be ignored.
REQ-021 On entering CLEAR, clr_idx SHALL be 0; CLEAR SHALL assert clr_req and move to WAIT_ACK the next cycle.
REQ-022 In WAIT_ACK, clr_req and clr_idx SHALL hold stable until clr_ack is sampled high.
REQ-023 On clr_ack with clr_idx < NUM_SEATS-1, clr_idx SHALL increment and clr_req SHALL stay high (back-to-back, no bubble).
REQ-024 On clr_ack with clr_idx == NUM_SEATS-1, clr_req SHALL drop and state SHALL go to DONE next cycle.
REQ-025 clr_ack outside WAIT_ACK SHALL be ignored.
REQ-026 DONE SHALL pulse done for exactly one cycle, then go to IDLE (behaviour with macro per REQ-031).
REQ-027 Ticks in CLEAR/WAIT_ACK/DONE SHALL NOT start a second clear sequence.

Reset
REQ-028 rst SHALL force state IDLE, trigger register 0, registered time copy 0, clr_idx 0, and clr_req, busy, done, cfg_err 0; cfg_ready reads 1.
REQ-029 rst asserted mid-sequence SHALL abort immediately; no further clr_req until re-armed and triggered.

Configuration
REQ-030 Macro SCHED_REPEAT_EN SHALL select daily re-arm.
REQ-031 Defined: DONE SHALL return to ARMED with the trigger register retained, so the same time triggers again after the 23:59 -> 00:00 wrap.
REQ-032 Undefined: DONE SHALL return to IDLE (one-shot); a new cfg transfer is needed to re-arm.

Verification
REQ-033 Program 08:30, step time_in 08:29 -> 08:30 -> clr_req on idx 0 within 2 cycles; ack each -> idx 0..39 in order, done pulse once.
REQ-034 Program hour=24 min=0 -> cfg_err one pulse, state stays IDLE, time 00:00 tick causes no clr_req.
REQ-035 Armed at 12:00, time_in held at 12:00 for 100 cycles after one tick -> exactly one sequence.
REQ-036 clr_ack held low 20 cycles during idx 5 -> clr_req and clr_idx=5 stable throughout; release -> idx 6.
REQ-037 Assert rst while clr_idx=17 -> all outputs reset values next edge, no done pulse.
REQ-038 With SCHED_REPEAT_EN, program 23:59, run 23:59 -> 00:00 -> ... -> 23:59 -> two complete sequences; without it, only one.
